muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the single-cycle MIPS core, sitting beside `alu` and owning the HI/LO register pair. It executes MULT, MULTU, DIV and DIVU over a parametrised operand width using a start/busy/done handshake. Results persist in HI/LO until the next operation completes. The core stalls on `busy` for MFHI/MFLO.

---
 rtl/muldiv_unit.sv | 102 ++++++++++
 tb/tb_muldiv_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit that owns the HI/LO pair; start/busy/done handshake.
// Define MULDIV_EARLY_OUT_EN to end a multiply once the remaining multiplier bits are all zero.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t             state;
  logic [1:0]         op_q;
  logic               neg, rneg, dbz;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mb;
  logic [2*WIDTH-1:0] acc, mc;
  logic               sa, sb, ge, last, accept, zero_div;
  logic [WIDTH-1:0]   aa, ab, dt;
  logic [WIDTH:0]     dsh;
  assign sa       = ~op[0] & a[WIDTH-1];
  assign sb       = ~op[0] & b[WIDTH-1];
  assign aa       = sa ? -a : a;
  assign ab       = sb ? -b : b;
  assign accept   = start && (state == IDLE || state == DONE);
  assign zero_div = op[1] && b == '0;
  // Restoring division: acc holds {remainder, dividend/quotient}, shifted left one bit per step.
  assign dsh = acc[2*WIDTH-1:WIDTH-1];
  assign ge  = dsh >= {1'b0, mb};
  assign dt  = dsh[WIDTH-1:0] - mb;
`ifdef MULDIV_EARLY_OUT_EN
  assign last = (cnt == CW'(WIDTH-1)) || (!op_q[1] && mb[WIDTH-1:1] == '0);
`else
  assign last = cnt == CW'(WIDTH-1);
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      op_q        <= '0;
      neg         <= 1'b0;
      rneg        <= 1'b0;
      dbz         <= 1'b0;
      cnt         <= '0;
      mb          <= '0;
      acc         <= '0;
      mc          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (accept) begin
        op_q  <= op;
        neg   <= sa ^ sb;
        rneg  <= sa;
        dbz   <= zero_div;
        cnt   <= '0;
        mb    <= ab;
        mc    <= {{WIDTH{1'b0}}, aa};
        acc   <= zero_div ? {a, {WIDTH{1'b1}}} : op[1] ? {{WIDTH{1'b0}}, aa} : '0;
        busy  <= 1'b1;
        state <= zero_div ? FIX : RUN;
      end else begin
        case (state)
          RUN: begin
            cnt <= cnt + CW'(1);
            if (op_q[1]) begin
              acc <= {ge ? dt : dsh[WIDTH-1:0], acc[WIDTH-2:0], ge};
            end else begin
              acc <= acc + (mb[0] ? mc : '0);
              mc  <= mc << 1;
              mb  <= mb >> 1;
            end
            if (last) state <= FIX;
          end
          FIX: begin
            {hi, lo} <= dbz ? acc : !op_q[1] ? (neg ? -acc : acc) :
                        {rneg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH],
                         neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]};
            done        <= 1'b1;
            div_by_zero <= dbz;
            busy        <= 1'b0;
            state       <= DONE;
          end
          DONE:    state <= IDLE;
          default: state <= state;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit; expected HI/LO come from a 64-bit reference model.
module tb_muldiv_unit;
  localparam int W = 32;
  logic         clk = 1'b0;
  logic         rst, start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;
  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    longint      sx = longint'($signed(x));
    longint      sy = longint'($signed(y));
    logic [63:0] p;
    e.dbz = 1'b0;
    case (o)
      2'd0: p = sx * sy;
      2'd1: p = {32'b0, x} * {32'b0, y};
      default: begin
        if (y == 0) begin
          p     = {x, 32'hFFFFFFFF};
          e.dbz = 1'b1;
        end else if (o == 2'd2) begin
          p = {32'(sx % sy), 32'(sx / sy)};
        end else begin
          p = {x % y, x / y};
        end
      end
    endcase
    e.hi = p[63:32];
    e.lo = p[31:0];
    return e;
  endfunction

  function automatic int lat(input logic [1:0] o, input logic [W-1:0] y);
    if (o[1] && y == 0) return 2;
`ifdef MULDIV_EARLY_OUT_EN
    if (!o[1]) begin
      logic [W-1:0] m = (o == 2'd0 && y[W-1]) ? -y : y;
      int k = 1;
      for (int i = 0; i < W; i++) if (m[i]) k = i + 1;
      return 2 + k;
    end
`endif
    return W + 2;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        check("dbz", div_by_zero, e.dbz);
      end
    end else if (div_by_zero) begin
      check("dbz_without_done", div_by_zero, 0);
    end
  end

  // Called just after a negedge; returns at the negedge where done is seen (DONE cycle).
  // ign > 0 pulses a DIVU 9/3 start at edge ign, which must be ignored.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int ign);
    int n;
    op = o; a = x; b = y; start = 1'b1;
    sb_q.push_back(model(o, x, y));
    @(posedge clk);
    #1 start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    for (n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("busy_rise", busy, 1);
        check("done_low", done, 0);
      end
      if (ign > 0 && n == ign) begin start = 1'b1; op = 2'd3; a = 9; b = 3; end
      if (ign > 0 && n == ign + 1) start = 1'b0;
      if (done) break;
    end
    check("latency", n, lat(o, y));
    check("busy_in_done", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    rst = 1'b0;
    @(negedge clk);
    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op(2'd0, 32'hFFFFFFFA, 32'd2, 0);
    run_op(2'd2, 32'hFFFFFFF9, 32'd2, 0);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(2'd3, 32'd6, 32'd0, 0);
    run_op(2'd1, 32'd7, 32'd9, 0);
    run_op(2'd2, 32'h1234, 32'd0, 0);
    run_op(2'd0, 32'h7FFFFFFF, 32'h80000000, 0);
    run_op(2'd1, 32'd3, 32'd5, 10);
    run_op(2'd3, 32'd9, 32'd3, 0);
    for (int i = 0; i < 10; i++) begin
      logic [1:0]   o = 2'($urandom_range(0, 3));
      logic [W-1:0] x = $urandom;
      logic [W-1:0] y = $urandom;
      if ($urandom_range(0, 4) == 0) y = 0;
      else if ($urandom_range(0, 2) == 0) y = $urandom_range(0, 255);
      if (i[0]) @(negedge clk);
      run_op(o, x, y, 0);
    end
    run_op(2'd1, 32'd2, 32'd3, 0);
    @(negedge clk);
    op = 2'd0; a = 32'hFFFFFFFB; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(2'd1, 32'd2, 32'd3, 0);
    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
